// File: rtl/sad_trigger_wrapper.sv
// SAD pattern trigger with a byte-wide register front-end: an N-sample ADC window is
// compared against a programmed reference and fires a one-shot level trigger below threshold.
module sad_trigger_wrapper #(
    parameter int         pBYTECNT_SIZE    = 7,
    parameter int         pREF_SAMPLES     = 8,
    parameter int         pBITS_PER_SAMPLE = 12,
    parameter logic [7:0] pREF_ADDR        = 8'h03,
    parameter logic [7:0] pTHRESH_ADDR     = 8'h04
) (
    input  logic                        clk_adc,
    input  logic                        reset,
    input  logic [pBITS_PER_SAMPLE-1:0] adc_datain,
    input  logic                        arm_i,
    inout  wire  [7:0]                  USB_Data,
    input  logic [7:0]                  USB_Addr,
    input  logic                        USB_RDn,
    input  logic                        USB_WRn,
    input  logic                        USB_CEn,
    input  logic                        USB_ALEn,
    output logic                        trigger
);
    localparam int N      = pREF_SAMPLES;
    localparam int W      = pBITS_PER_SAMPLE;
    localparam int BC     = pBYTECNT_SIZE;
    localparam int IDX_W  = $clog2(N);
    localparam int SAD_W  = W + $clog2(N);
    localparam int FILL_W = $clog2(N + 1);
    localparam logic [BC-2:0]     N_IDX     = (BC-1)'(N);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(N);

    typedef enum logic [1:0] {ST_IDLE, ST_ARMED, ST_FIRED} state_t;

    // Strobe synchronizers: bit [1] is the synchronized level, bit [2] its previous value.
    logic [2:0] rd_sync, wr_sync;
    logic [1:0] ce_sync, ale_sync;
    logic       rd_rise, wr_rise, ce_act, ale_act;

    always_ff @(posedge clk_adc) begin
        if (reset) begin
            rd_sync  <= '1;
            wr_sync  <= '1;
            ce_sync  <= '1;
            ale_sync <= '1;
        end else begin
            rd_sync  <= {rd_sync[1:0], USB_RDn};
            wr_sync  <= {wr_sync[1:0], USB_WRn};
            ce_sync  <= {ce_sync[0], USB_CEn};
            ale_sync <= {ale_sync[0], USB_ALEn};
        end
    end

    assign ce_act  = ~ce_sync[1];
    assign ale_act = ~ale_sync[1];
    assign rd_rise = rd_sync[1] & ~rd_sync[2];
    assign wr_rise = wr_sync[1] & ~wr_sync[2];

    logic [7:0]       reg_address;
    logic [BC-1:0]    bytecnt;
    logic [BC-2:0]    ref_idx;
    logic [IDX_W-1:0] ref_sel;
    logic [W-1:0]     ref_mem [N];
    logic [31:0]      threshold;
    logic             ref_wr, thr_wr, ref_hit, thr_hit;
    logic [15:0]      ref_cur;
    logic [W-1:0]     ref_new;
    logic [7:0]       rd_byte;

    assign ref_idx = bytecnt[BC-1:1];
    assign ref_sel = ref_idx[IDX_W-1:0];
    assign ref_hit = (reg_address == pREF_ADDR) && (ref_idx < N_IDX);
    assign thr_hit = (reg_address == pTHRESH_ADDR) && (bytecnt < BC'(4));
    assign ref_wr  = ce_act && wr_rise && ref_hit;
    assign thr_wr  = ce_act && wr_rise && thr_hit;

    always_comb begin
        ref_cur = 16'(ref_mem[ref_sel]);
        ref_new = W'(bytecnt[0] ? {USB_Data, ref_cur[7:0]} : {ref_cur[15:8], USB_Data});
        rd_byte = '0;
        if (ref_hit)
            rd_byte = bytecnt[0] ? ref_cur[15:8] : ref_cur[7:0];
        else if (thr_hit)
            rd_byte = threshold[{bytecnt[1:0], 3'b000} +: 8];
    end

    assign USB_Data = (!USB_CEn && !USB_RDn) ? rd_byte : 8'hzz;

    // NOTE: the reference store must be cleared by reset, so it is a flop array, not a RAM.
    always_ff @(posedge clk_adc) begin
        if (reset) begin
            reg_address <= '0;
            bytecnt     <= '0;
            threshold   <= '0;
            for (int i = 0; i < N; i++) ref_mem[i] <= '0;
        end else begin
            if (ce_act && ale_act) begin
                reg_address <= USB_Addr;
                bytecnt     <= '0;
            end else if (ce_act && (wr_rise || rd_rise)) begin
                bytecnt <= bytecnt + BC'(1);
            end
            if (ref_wr) ref_mem[ref_sel] <= ref_new;
            if (thr_wr) threshold[{bytecnt[1:0], 3'b000} +: 8] <= USB_Data;
        end
    end

    logic [W-1:0]     win [N];
    logic [SAD_W-1:0] sad;
    logic [31:0]      sad_ext;

    // Window contents are only trusted once fill reaches N, so they need no reset.
    always_ff @(posedge clk_adc) begin
        for (int i = 0; i < N - 1; i++) win[i] <= win[i+1];
        win[N-1] <= adc_datain;
    end

    // NOTE: blocking accumulation is correct here because this block is purely combinational.
    always_comb begin
        sad = '0;
        for (int i = 0; i < N; i++)
            sad = sad + SAD_W'(win[i] >= ref_mem[i] ? win[i] - ref_mem[i] : ref_mem[i] - win[i]);
    end

    assign sad_ext = 32'(sad);

    state_t            state, state_next;
    logic [FILL_W-1:0] fill;
    logic              match;

    assign match = (state == ST_ARMED) && (fill == FILL_FULL) && (sad_ext < threshold);

    always_ff @(posedge clk_adc) begin
        if (reset) begin
            state <= ST_IDLE;
            fill  <= '0;
        end else begin
            state <= state_next;
            if (arm_i)
                fill <= '0;
            else if (state == ST_ARMED && fill != FILL_FULL)
                fill <= fill + FILL_W'(1);
        end
    end

    // arm_i outranks a same-cycle match; a match disarms until the next arm.
    always_comb begin
        state_next = state;
        if (arm_i)
            state_next = ST_ARMED;
        else if (match)
            state_next = ST_FIRED;
    end

    assign trigger = (state == ST_FIRED);

endmodule

// File: tb/tb_sad_trigger_wrapper.sv
// Self-checking bench for sad_trigger_wrapper: queue-based behavioural model of the
// armed window/SAD rules, register transactions through the strobed byte bus.
module tb_sad_trigger_wrapper;
    localparam int N = 8;
    localparam int W = 12;

    typedef int win_t [N];

    logic         clk_adc = 1'b0;
    logic         reset, arm_i;
    logic [W-1:0] adc_datain;
    logic [7:0]   usb_addr, data_drv;
    logic         usb_rdn, usb_wrn, usb_cen, usb_alen, data_oe;
    wire  [7:0]   usb_data;
    logic         trigger;

    assign usb_data = data_oe ? data_drv : 8'hzz;

    sad_trigger_wrapper dut (
        .clk_adc   (clk_adc),
        .reset     (reset),
        .adc_datain(adc_datain),
        .arm_i     (arm_i),
        .USB_Data  (usb_data),
        .USB_Addr  (usb_addr),
        .USB_RDn   (usb_rdn),
        .USB_WRn   (usb_wrn),
        .USB_CEn   (usb_cen),
        .USB_ALEn  (usb_alen),
        .trigger   (trigger)
    );

    always #5 clk_adc = ~clk_adc;

    int     errors = 0;
    int     checks = 0;
    bit     cmp_en = 1'b0;
    int     pat [N];
    int     ref_m [N];
    longint thr_m = 0;
    bit     armed_m = 1'b0;
    bit     trig_m = 1'b0;
    int     hist [$];
    int     cur_addr = 0;
    int     byte_idx = 0;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int sad_of(input win_t w);
        int s = 0;
        for (int i = 0; i < N; i++)
            s += (w[i] > ref_m[i]) ? w[i] - ref_m[i] : ref_m[i] - w[i];
        return s;
    endfunction

    function automatic int window_sad();
        win_t w;
        for (int i = 0; i < N; i++) w[i] = hist[hist.size() - N + i];
        return sad_of(w);
    endfunction

    // Advance one clock; the model decides what this edge does from the inputs now applied.
    task automatic tick();
        bit armed_n, trig_n, clr;
        armed_n = armed_m;
        trig_n  = trig_m;
        clr     = 1'b0;
        if (reset) begin
            armed_n = 1'b0;
            trig_n  = 1'b0;
            clr     = 1'b1;
        end else if (arm_i) begin
            armed_n = 1'b1;
            trig_n  = 1'b0;
            hist.delete();
        end else if (armed_m) begin
            if (hist.size() >= N && longint'(window_sad()) < thr_m) begin
                trig_n  = 1'b1;
                armed_n = 1'b0;
            end else begin
                hist.push_back(int'(adc_datain));
                if (hist.size() > N) void'(hist.pop_front());
            end
        end
        @(posedge clk_adc);
        armed_m = armed_n;
        trig_m  = trig_n;
        if (clr) begin
            hist.delete();
            for (int i = 0; i < N; i++) ref_m[i] = 0;
            thr_m = 0;
        end
        #1;
    endtask

    always @(negedge clk_adc)
        if (cmp_en) check("trigger_vs_model", trigger, trig_m);

    function automatic int exp_byte();
        if (cur_addr == 3 && byte_idx / 2 < N)
            return (byte_idx % 2 == 1) ? (ref_m[byte_idx/2] >> 8) & 255 : ref_m[byte_idx/2] & 255;
        if (cur_addr == 4 && byte_idx < 4)
            return int'((thr_m >> (8 * byte_idx)) & 255);
        return 0;
    endfunction

    task automatic bus_addr(input int a);
        usb_addr = 8'(a);
        usb_cen  = 1'b0;
        usb_alen = 1'b0;
        repeat (3) tick();
        usb_alen = 1'b1;
        repeat (2) tick();
        cur_addr = a;
        byte_idx = 0;
    endtask

    task automatic bus_write(input int d);
        int k;
        data_drv = 8'(d);
        data_oe  = 1'b1;
        usb_wrn  = 1'b0;
        repeat (3) tick();
        usb_wrn = 1'b1;
        repeat (4) tick();
        data_oe = 1'b0;
        if (cur_addr == 3 && byte_idx / 2 < N) begin
            k = byte_idx / 2;
            if (byte_idx % 2 == 0) ref_m[k] = (ref_m[k] & 32'hFF00) | d;
            else                   ref_m[k] = (ref_m[k] & 255) | (d << 8);
            ref_m[k] = ref_m[k] % (1 << W);
        end else if (cur_addr == 4 && byte_idx < 4) begin
            thr_m = (thr_m & ~(64'hFF << (8 * byte_idx))) | (longint'(d) << (8 * byte_idx));
        end
        byte_idx = (byte_idx + 1) % 128;
    endtask

    task automatic bus_read(input string name, input int exp);
        usb_rdn = 1'b0;
        repeat (2) tick();
        check(name, usb_data, exp);
        usb_rdn = 1'b1;
        repeat (4) tick();
        byte_idx = (byte_idx + 1) % 128;
    endtask

    task automatic bus_end();
        usb_cen = 1'b1;
        repeat (2) tick();
    endtask

    task automatic write_refs();
        bus_addr(3);
        for (int i = 0; i < N; i++) begin
            bus_write(pat[i] & 255);
            bus_write(pat[i] >> 8);
        end
    endtask

    task automatic write_thr(input int t);
        bus_addr(4);
        for (int i = 0; i < 4; i++) bus_write((t >> (8 * i)) & 255);
        bus_end();
    endtask

    task automatic feed(input int v);
        adc_datain = W'(v);
        tick();
    endtask

    task automatic feed_pat(input int dev_idx, input int dev);
        for (int i = 0; i < N; i++) feed(pat[i] + ((i == dev_idx) ? dev : 0));
    endtask

    task automatic arm(input int v);
        adc_datain = W'(v);
        arm_i = 1'b1;
        tick();
        arm_i = 1'b0;
    endtask

    initial begin
        win_t w;
        reset = 1'b1; arm_i = 1'b0; adc_datain = '0; usb_addr = '0;
        usb_rdn = 1'b1; usb_wrn = 1'b1; usb_cen = 1'b1; usb_alen = 1'b1;
        data_drv = '0; data_oe = 1'b0;
        for (int i = 0; i < N; i++) pat[i] = 100 * (i + 1);

        repeat (3) tick();
        reset = 1'b0;
        tick();
        cmp_en = 1'b1;
        check("trigger_after_reset", trigger, 0);

        // Bus must be released while idle: the bench's own value comes back unchanged.
        data_drv = 8'h5A; data_oe = 1'b1;
        tick();
        check("bus_release", usb_data, 8'h5A);
        data_oe = 1'b0;
        bus_addr(4);
        for (int b = 0; b < 4; b++) bus_read("thr_after_reset", 0);
        bus_end();

        // Program reference (plus 4 bytes past the register) and threshold, then read back.
        write_refs();
        repeat (4) bus_write(255);
        bus_end();
        write_thr(50);
        check("model_ref2_pin", ref_m[2], 300);
        for (int i = 0; i < N; i++) w[i] = pat[i];
        check("model_sad0_pin", sad_of(w), 0);
        w[3] += 49;
        check("model_sad49_pin", sad_of(w), 49);
        bus_addr(3);
        for (int b = 0; b < 20; b++)
            bus_read("ref_readback", (b == 4) ? 8'h2C : (b == 5) ? 8'h01 : (b >= 16) ? 0 : exp_byte());
        bus_end();
        bus_addr(4);
        bus_read("thr_byte0", 50);
        for (int b = 1; b < 4; b++) bus_read("thr_byte_hi", 0);
        bus_end();

        // Random lead-in, then the exact pattern.
        arm($urandom_range(4095, 0));
        repeat (20) feed($urandom_range(4095, 0));
        feed_pat(-1, 0);
        check("trig_before_edge", trigger, 0);
        feed($urandom_range(4095, 0));
        check("trig_1cycle", trigger, 1);
        repeat (5) feed($urandom_range(4095, 0));
        check("trig_hold", trigger, 1);

        // Deviations at and around the threshold.
        arm($urandom_range(4095, 0));
        check("rearm_drop", trigger, 0);
        feed_pat(3, 50);
        feed(0);
        check("dev50_none", trigger, 0);
        feed_pat(7, 70);
        feed(0);
        check("dev70_none", trigger, 0);
        feed_pat(2, 49);
        feed(0);
        check("dev49_trig", trigger, 1);

        // Pattern completes while only N-1 samples are counted.
        arm(pat[0]);
        check("rearm_drop2", trigger, 0);
        for (int i = 1; i < N; i++) feed(pat[i]);
        feed(0);
        check("fill_short", trigger, 0);
        repeat (4) feed($urandom_range(4095, 0));

        // Threshold of zero can never match, even on an exact pattern.
        adc_datain = '0;
        write_thr(0);
        feed_pat(-1, 0);
        feed(0);
        check("thr0_none", trigger, 0);

        // Reset mid-pattern aborts the arm and clears the registers.
        adc_datain = '0;
        write_thr(50);
        arm(0);
        for (int i = 0; i < 4; i++) feed(pat[i]);
        reset = 1'b1;
        feed(pat[4]);
        reset = 1'b0;
        for (int i = 5; i < N; i++) feed(pat[i]);
        feed(0);
        check("reset_abort", trigger, 0);
        bus_addr(3);
        for (int b = 0; b < 2 * N; b++) bus_read("ref_cleared", 0);
        bus_end();
        bus_addr(4);
        for (int b = 0; b < 4; b++) bus_read("thr_cleared", 0);
        bus_end();

        // Reset and arm together: reset wins, so the pattern must not fire.
        reset = 1'b1; arm_i = 1'b1;
        tick();
        reset = 1'b0; arm_i = 1'b0;
        adc_datain = '0;
        write_refs();
        bus_end();
        write_thr(50);
        feed_pat(-1, 0);
        feed(0);
        check("reset_wins", trigger, 0);
        arm(0);
        feed_pat(-1, 0);
        feed(0);
        check("final_trig", trigger, 1);

        cmp_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
